// File: rtl/sm83_irq_pkg.sv
// Shared constants for the SM83-style interrupt flag block.
package sm83_irq_pkg;

    localparam logic [15:0] IF_ADDR     = 16'hFF0F;
    localparam int          NUM_SRC     = 5;
    localparam int          SYNC_STAGES = 2;

    // Source bit positions within IF / IRQ_SRC
    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer for asynchronous active-low lines.
// Flops reset to 1 so an idle (released) line reads as released.
module irq_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sync_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_ff;

    // Shift raw input through STAGES flops; stage 0 samples the async line
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_ff <= '1;
        else if (i_sync_rst)
            r_ff <= '1;
        else
            r_ff <= {r_ff[STAGES-2:0], i_d};
    end

    assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/cpu_irq_ctrl.sv
// Interrupt flag (IF) register with source edge detection, CPU
// read/write/ack access and joypad STOP-mode wake.
module cpu_irq_ctrl #(
    parameter logic [15:0] IF_ADDR     = sm83_irq_pkg::IF_ADDR,
    parameter int          NUM_SRC     = sm83_irq_pkg::NUM_SRC,
    parameter int          SYNC_STAGES = sm83_irq_pkg::SYNC_STAGES
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               SYNC_RESET,
    input  logic [15:0]        A,
    input  logic [7:0]         D_IN,
    output logic [7:0]         D_OUT,
    output logic               D_OE,
    input  logic               RD,
    input  logic               WR,
    input  logic               MMIO_REQ,
    input  logic [NUM_SRC-1:0] IRQ_SRC,
    input  logic [3:0]         JOYP_N,
    input  logic [7:0]         CPU_IRQ_ACK,
    output logic [7:0]         CPU_IRQ_TRIG,
    output logic               WAKE
);

    import sm83_irq_pkg::*;

    logic [NUM_SRC-1:0] r_if;
    logic [NUM_SRC-1:0] r_src_prev;
    logic               r_joy_prev;
    logic               r_armed;     // low for one edge after reset: history reload only
    logic               r_wake;

    logic [3:0]         w_joy_sync;
    logic               w_joy_all;
    logic               w_hit;
    logic               w_wr_hit;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_if_next;
    logic               w_unused;

    irq_sync #(
        .WIDTH  (4),
        .STAGES (SYNC_STAGES)
    ) u_joy_sync (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_sync_rst (SYNC_RESET),
        .i_d        (JOYP_N),
        .o_q        (w_joy_sync)
    );

    assign w_joy_all = &w_joy_sync;
    assign w_hit     = MMIO_REQ & (A == IF_ADDR);
    assign w_wr_hit  = WR & w_hit;

    // Rising source edges, plus first-key-pressed on the joypad bit
    always_comb begin
        w_edge = '0;
        if (r_armed) begin
            w_edge = IRQ_SRC & ~r_src_prev;
            w_edge[IRQ_JOYPAD] = w_edge[IRQ_JOYPAD] | (r_joy_prev & ~w_joy_all);
        end
    end

    // Per-bit next IF: source edge beats CPU write, write beats ack
    always_comb begin
        w_if_next = r_if;
        for (int n = 0; n < NUM_SRC; n++) begin
            if (w_edge[n])
                w_if_next[n] = 1'b1;
            else if (w_wr_hit)
                w_if_next[n] = D_IN[n];
            else if (CPU_IRQ_ACK[n])
                w_if_next[n] = 1'b0;
        end
    end

    // Flag, edge history and wake registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_if       <= '0;
            r_src_prev <= '0;
            r_joy_prev <= 1'b1;
            r_armed    <= 1'b0;
            r_wake     <= 1'b0;
        end else if (SYNC_RESET) begin
            r_if       <= '0;
            r_src_prev <= '0;
            r_joy_prev <= 1'b1;
            r_armed    <= 1'b0;
            r_wake     <= 1'b0;
        end else begin
            r_if       <= w_if_next;
            r_src_prev <= IRQ_SRC;
            r_joy_prev <= w_joy_all;
            r_armed    <= 1'b1;
            r_wake     <= |(~w_joy_sync);
        end
    end

    assign CPU_IRQ_TRIG = {{(8-NUM_SRC){1'b0}}, r_if};
    assign WAKE         = r_wake;

    // Read path returns the pre-edge flag value; unused upper bits read as 1
    assign D_OE  = RD & w_hit & ~RESET;
    assign D_OUT = D_OE ? {{(8-NUM_SRC){1'b1}}, r_if} : 8'h00;

    assign w_unused = ^{CPU_IRQ_ACK[7:NUM_SRC], D_IN[7:NUM_SRC]};

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Directed self-checking bench for cpu_irq_ctrl.
module tb_cpu_irq_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        SYNC_RESET;
    logic [15:0] A;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        RD;
    logic        WR;
    logic        MMIO_REQ;
    logic [4:0]  IRQ_SRC;
    logic [3:0]  JOYP_N;
    logic [7:0]  CPU_IRQ_ACK;
    logic [7:0]  CPU_IRQ_TRIG;
    logic        WAKE;

    int errors = 0;
    int checks = 0;

    cpu_irq_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .SYNC_RESET   (SYNC_RESET),
        .A            (A),
        .D_IN         (D_IN),
        .D_OUT        (D_OUT),
        .D_OE         (D_OE),
        .RD           (RD),
        .WR           (WR),
        .MMIO_REQ     (MMIO_REQ),
        .IRQ_SRC      (IRQ_SRC),
        .JOYP_N       (JOYP_N),
        .CPU_IRQ_ACK  (CPU_IRQ_ACK),
        .CPU_IRQ_TRIG (CPU_IRQ_TRIG),
        .WAKE         (WAKE)
    );

    always #5 CLK = ~CLK;

    // One clock: rising edge, then settle at the falling edge
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic bus_idle();
        A = 16'h0000; D_IN = 8'h00; RD = 1'b0; WR = 1'b0; MMIO_REQ = 1'b0;
        CPU_IRQ_ACK = 8'h00;
    endtask

    task automatic write_if(input logic [7:0] val);
        A = 16'hFF0F; MMIO_REQ = 1'b1; WR = 1'b1; D_IN = val;
        tick();
        bus_idle();
    endtask

    task automatic test_reset();
        RESET = 1'b1; SYNC_RESET = 1'b0; IRQ_SRC = 5'b00100; JOYP_N = 4'hF;
        bus_idle();
        A = 16'hFF0F; MMIO_REQ = 1'b1; RD = 1'b1;
        tick();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL reset_trig got=%h exp=00", CPU_IRQ_TRIG); end
        checks++;
        if (D_OE !== 1'b0) begin errors++; $display("FAIL reset_doe got=%b exp=0", D_OE); end
        checks++;
        if (WAKE !== 1'b0) begin errors++; $display("FAIL reset_wake got=%b exp=0", WAKE); end
        // source already high at release must not set IF
        RESET = 1'b0; bus_idle();
        tick(); tick();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL reset_release_high got=%h exp=00", CPU_IRQ_TRIG); end
        IRQ_SRC = 5'b0;
        tick();
    endtask

    task automatic test_edge_read();
        IRQ_SRC = 5'b00100;
        tick();
        IRQ_SRC = 5'b00000;
        checks++;
        if (CPU_IRQ_TRIG !== 8'h04) begin errors++; $display("FAIL edge_trig got=%h exp=04", CPU_IRQ_TRIG); end
        A = 16'hFF0F; MMIO_REQ = 1'b1; RD = 1'b1;
        #1;
        checks++;
        if (D_OUT !== 8'hE4 || D_OE !== 1'b1) begin errors++; $display("FAIL read_if got=%h/%b exp=e4/1", D_OUT, D_OE); end
        MMIO_REQ = 1'b0;
        #1;
        checks++;
        if (D_OUT !== 8'h00 || D_OE !== 1'b0) begin errors++; $display("FAIL read_nomm got=%h/%b exp=00/0", D_OUT, D_OE); end
        MMIO_REQ = 1'b1; A = 16'hFF0E;
        #1;
        checks++;
        if (D_OE !== 1'b0) begin errors++; $display("FAIL read_wrongaddr got=%b exp=0", D_OE); end
        bus_idle();
        CPU_IRQ_ACK = 8'h04;
        tick();
        bus_idle();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL ack_clear got=%h exp=00", CPU_IRQ_TRIG); end
    endtask

    task automatic test_held_ack();
        IRQ_SRC = 5'b00001;
        for (int c = 0; c < 10; c++) begin
            CPU_IRQ_ACK = (c == 3) ? 8'h01 : 8'h00;
            tick();
            if (c == 2) begin
                checks++;
                if (CPU_IRQ_TRIG !== 8'h01) begin errors++; $display("FAIL held_set got=%h exp=01", CPU_IRQ_TRIG); end
            end
        end
        CPU_IRQ_ACK = 8'h00;
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL held_no_reset got=%h exp=00", CPU_IRQ_TRIG); end
        IRQ_SRC = 5'b00000;
        tick();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL held_fall got=%h exp=00", CPU_IRQ_TRIG); end
        IRQ_SRC = 5'b00001;
        tick();
        IRQ_SRC = 5'b00000;
        checks++;
        if (CPU_IRQ_TRIG !== 8'h01) begin errors++; $display("FAIL held_reedge got=%h exp=01", CPU_IRQ_TRIG); end
        CPU_IRQ_ACK = 8'h01;
        tick();
        CPU_IRQ_ACK = 8'h00;
    endtask

    task automatic test_priority();
        write_if(8'h1D);
        checks++;
        if (CPU_IRQ_TRIG !== 8'h1D) begin errors++; $display("FAIL prio_preload got=%h exp=1d", CPU_IRQ_TRIG); end
        // edge on bit1 + ack bit1 + write 0 + simultaneous read
        IRQ_SRC = 5'b00010; CPU_IRQ_ACK = 8'h02;
        A = 16'hFF0F; MMIO_REQ = 1'b1; WR = 1'b1; RD = 1'b1; D_IN = 8'h00;
        #1;
        checks++;
        if (D_OUT !== 8'hFD) begin errors++; $display("FAIL rdwr_old got=%h exp=fd", D_OUT); end
        tick();
        bus_idle(); IRQ_SRC = 5'b0;
        checks++;
        if (CPU_IRQ_TRIG !== 8'h02) begin errors++; $display("FAIL prio_edge_wr_ack got=%h exp=02", CPU_IRQ_TRIG); end
        // write beats ack
        CPU_IRQ_ACK = 8'h03;
        A = 16'hFF0F; MMIO_REQ = 1'b1; WR = 1'b1; D_IN = 8'hE1;
        tick();
        bus_idle();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h01) begin errors++; $display("FAIL prio_wr_ack got=%h exp=01", CPU_IRQ_TRIG); end
        write_if(8'h00);
    endtask

    task automatic test_write_hit();
        A = 16'hFF0F; MMIO_REQ = 1'b0; WR = 1'b1; D_IN = 8'hFF;
        tick();
        bus_idle();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL wr_nomm got=%h exp=00", CPU_IRQ_TRIG); end
        A = 16'hFF0E; MMIO_REQ = 1'b1; WR = 1'b1; D_IN = 8'hFF;
        tick();
        bus_idle();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL wr_wrongaddr got=%h exp=00", CPU_IRQ_TRIG); end
        write_if(8'hFF);
        checks++;
        if (CPU_IRQ_TRIG !== 8'h1F) begin errors++; $display("FAIL wr_hit got=%h exp=1f", CPU_IRQ_TRIG); end
        A = 16'hFF0F; MMIO_REQ = 1'b1; RD = 1'b1;
        #1;
        checks++;
        if (D_OUT !== 8'hFF || D_OE !== 1'b1) begin errors++; $display("FAIL wr_readback got=%h/%b exp=ff/1", D_OUT, D_OE); end
        bus_idle();
        write_if(8'h00);
    endtask

    task automatic test_back_to_back();
        IRQ_SRC = 5'b00001;
        tick();
        IRQ_SRC = 5'b00010;
        tick();
        IRQ_SRC = 5'b01000;
        tick();
        IRQ_SRC = 5'b00000;
        checks++;
        if (CPU_IRQ_TRIG !== 8'h0B) begin errors++; $display("FAIL b2b got=%h exp=0b", CPU_IRQ_TRIG); end
        write_if(8'h00);
    endtask

    task automatic test_joypad();
        #3 JOYP_N = 4'hB;
        tick(); tick(); tick();
        checks++;
        if (WAKE !== 1'b1) begin errors++; $display("FAIL joy_wake got=%b exp=1", WAKE); end
        checks++;
        if (CPU_IRQ_TRIG !== 8'h10) begin errors++; $display("FAIL joy_if got=%h exp=10", CPU_IRQ_TRIG); end
        CPU_IRQ_ACK = 8'h10;
        tick();
        CPU_IRQ_ACK = 8'h00;
        tick(); tick();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00 || WAKE !== 1'b1) begin errors++; $display("FAIL joy_held got=%h/%b exp=00/1", CPU_IRQ_TRIG, WAKE); end
        #2 JOYP_N = 4'hF;
        tick(); tick(); tick();
        checks++;
        if (WAKE !== 1'b0) begin errors++; $display("FAIL joy_release got=%b exp=0", WAKE); end
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL joy_release_if got=%h exp=00", CPU_IRQ_TRIG); end
    endtask

    task automatic test_resets();
        write_if(8'h1F);
        checks++;
        if (CPU_IRQ_TRIG !== 8'h1F) begin errors++; $display("FAIL rst_preload got=%h exp=1f", CPU_IRQ_TRIG); end
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL async_rst got=%h exp=00", CPU_IRQ_TRIG); end
        A = 16'hFF0F; MMIO_REQ = 1'b1; RD = 1'b1;
        #1;
        checks++;
        if (D_OE !== 1'b0) begin errors++; $display("FAIL async_rst_doe got=%b exp=0", D_OE); end
        bus_idle();
        @(negedge CLK);
        RESET = 1'b0;
        tick(); tick();
        write_if(8'h15);
        // sync reset beats a source edge and a write in the same cycle
        SYNC_RESET = 1'b1; IRQ_SRC = 5'b01000;
        A = 16'hFF0F; MMIO_REQ = 1'b1; WR = 1'b1; D_IN = 8'h1F;
        tick();
        SYNC_RESET = 1'b0; bus_idle();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL sync_rst got=%h exp=00", CPU_IRQ_TRIG); end
        tick(); tick();
        checks++;
        if (CPU_IRQ_TRIG !== 8'h00) begin errors++; $display("FAIL sync_rst_held got=%h exp=00", CPU_IRQ_TRIG); end
        IRQ_SRC = 5'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_edge_read();
        test_held_ack();
        test_priority();
        test_write_hit();
        test_back_to_back();
        test_joypad();
        test_resets();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_irq_ctrl.md
CPU_IRQ_CTRL -- requirements
Module: cpu_irq_ctrl

Interface
REQ-001 Parameter IF_ADDR, 16'hFF0F, bus address of the interrupt-flag (IF) register.
REQ-002 Parameter NUM_SRC, 5, number of interrupt sources (VBlank, STAT, Timer, Serial, Joypad; bit 0 = VBlank).
REQ-003 Parameter SYNC_STAGES, 2, flop depth of the joypad wake synchronizer (minimum 2).
REQ-004 CLK  in  1  single system clock; all state updates on rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 SYNC_RESET  in  1  synchronous, active-high clear, sampled on CLK.
REQ-007 A  in  16  CPU address bus.
REQ-008 D_IN  in  8  CPU write data.
REQ-009 D_OUT  out  8  read data for IF.
REQ-010 D_OE  out  1  read-data drive enable.
REQ-011 RD  in  1  CPU read strobe, active-high.
REQ-012 WR  in  1  CPU write strobe, active-high.
REQ-013 MMIO_REQ  in  1  high when A is in 0xFExx/0xFFxx.
REQ-014 IRQ_SRC  in  NUM_SRC  peripheral request lines, synchronous to CLK.
REQ-015 JOYP_N  in  4  raw asynchronous joypad lines, active-low.
REQ-016 CPU_IRQ_ACK  in  8  per-bit acknowledge from the CPU core, level, active-high.
REQ-017 CPU_IRQ_TRIG  out  8  pending requests to the CPU core.
REQ-018 WAKE  out  1  STOP-mode wake request to the CPU core.

Function
REQ-019 Flag register IF[NUM_SRC-1:0] shall be held in flops; IF bit n shall set on a rising edge of IRQ_SRC[n], detected as IRQ_SRC[n]=1 this cycle and 0 in the previous cycle (previous-value register).
REQ-020 Held-high IRQ_SRC[n] shall set IF[n] only once; after a 0 cycle, a new rising edge shall set it again.
REQ-021 Register hit: hit = MMIO_REQ & (A == IF_ADDR).
REQ-022 WR & hit shall load IF from D_IN[NUM_SRC-1:0] at the next edge; D_IN[7:NUM_SRC] shall be ignored.
REQ-023 CPU_IRQ_ACK[n]=1 shall clear IF[n] at the next edge; ACK bits >= NUM_SRC shall be ignored.
REQ-024 Per-bit priority in one cycle shall be: source edge (set) > write > ack. A new event is never lost.
REQ-025 The next state of IF[n] shall be: edge[n] ? 1 : (WR&hit) ? D_IN[n] : ACK[n] ? 0 : IF[n].
REQ-026 CPU_IRQ_TRIG shall equal {zeros, IF}, driven directly from the flops with zero added latency. An edge seen at clock k shall appear on TRIG after edge k.
REQ-027 RD & hit shall give D_OE=1 and D_OUT={ones[7:NUM_SRC], IF}, combinational. Otherwise D_OE=0 and D_OUT=8'h00.
REQ-028 A read in the same cycle as a set or ack shall return the pre-edge IF value.
REQ-029 JOYP_N shall pass through a SYNC_STAGES-deep synchronizer. WAKE shall be the registered OR of the inverted synchronized lines, so it is high while any key is held.
REQ-030 A falling edge of (&synchronized JOYP_N), i.e. the first key pressed, shall also set IF[4], ORed with the IRQ_SRC[4] edge.
REQ-031 Simultaneous RD and WR to hit shall read the old value and write the new value.

Reset
REQ-032 RESET shall asynchronously clear IF, the edge-detect history, the synchronizer flops (to 1, i.e. released) and WAKE. CPU_IRQ_TRIG shall be 8'h00 and D_OE=0 while RESET is high.
REQ-033 SYNC_RESET shall produce the same state as RESET at the next edge and shall take priority over all REQ-024 terms.
REQ-034 Edge-detect history shall reload from current inputs on the first edge after reset release, so a source already high at release shall not set IF.

Structure
REQ-035 Package sm83_irq_pkg shall hold IF_ADDR, NUM_SRC and the source bit indices (IRQ_VBLANK=0 .. IRQ_JOYPAD=4).
REQ-036 Sub-module irq_sync (parameterized multi-flop synchronizer, async reset to 1) shall implement REQ-029.

Verification
REQ-037 IRQ_SRC=5'b00100 for 1 cycle -> CPU_IRQ_TRIG=8'h04 after next edge; read FF0F -> D_OUT=8'hE4, D_OE=1.
REQ-038 IRQ_SRC[0] held high 10 cycles, ACK[0] pulsed at cycle 3 -> IF[0] cleared and not re-set until IRQ_SRC[0] toggles low then high.
REQ-039 Same cycle: IRQ_SRC[1] rises, ACK=8'h02, write D_IN=8'h00 to FF0F -> IF=5'b00010.
REQ-040 Write 8'hFF to FF0F with MMIO_REQ=0 -> IF unchanged. With MMIO_REQ=1 -> IF=5'h1F and read returns 8'hFF.
REQ-041 JOYP_N 4'hF->4'hB asynchronously -> WAKE=1 and IF[4]=1 within SYNC_STAGES+1 edges; release -> WAKE=0.
REQ-042 IF=5'h1F, assert RESET mid-cycle -> TRIG=8'h00 immediately. SYNC_RESET with simultaneous source edge -> IF=0.
